// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver FSM state encoding.
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_CNT_W      = $clog2(UART_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer plus history flop with falling-edge strobe.
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // Flops reset to the idle-high line level so reset release is not seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign dout = sync;
  assign fall = hist & ~sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART byte receiver with valid/ready holding register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      clk_bps,
  output logic                      bps_start,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      overrun
);

  rx_state_t                 state;
  logic [UART_DATA_BITS-1:0] shift;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic                      rx_s;
  logic                      rx_fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx),
    .dout  (rx_s),
    .fall  (rx_fall)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_err_q;
  logic par_ok;

  // Total ones over data plus parity must be odd for odd parity, even otherwise
  assign par_ok     = ((^shift) ^ par_bit) == PARITY_ODD;
  assign parity_err = par_err_q;
`else
  logic unused_cfg;

  assign unused_cfg = PARITY_ODD;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bps_start <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state     <= ST_START;
            bps_start <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_bps) begin
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              // Line back high at mid start bit: a glitch, drop it silently
              state     <= ST_IDLE;
              bps_start <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (clk_bps) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (clk_bps) begin
            par_bit <= rx_s;
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (clk_bps) begin
            // Leave at mid stop bit so the next start edge is not missed
            state     <= ST_IDLE;
            bps_start <= 1'b0;
            if (!rx_s)
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (!par_ok)
              par_err_q <= 1'b1;
`endif
            else if (rx_valid)
              overrun <= 1'b1;
            else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          bps_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: randomized self-checking bench with a frame-level reference model.
`default_nettype none

module tb_uart_rx_frame;

  localparam int BIT        = 51;
  localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam int NSTROBE = 11;
`else
  localparam bit PAR_EN  = 1'b0;
  localparam int NSTROBE = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clk_bps;
  logic       rx_ready;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the holding register and pulse totals should be
  bit       exp_valid = 1'b0;
  bit [7:0] exp_data  = 8'h00;
  int       exp_fe = 0, exp_pe = 0, exp_ov = 0;
  int       cnt_fe = 0, cnt_pe = 0, cnt_ov = 0;
  int       hi_len = 0;
  int       bps_cnt;

  uart_rx_frame #(.PARITY_ODD(PARITY_ODD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .clk_bps    (clk_bps),
    .bps_start  (bps_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;

  // Baud generator: 51-clock bit period, mid-bit strobe, held in reset while disabled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bps_cnt <= 0;
      clk_bps <= 1'b0;
    end else if (!bps_start) begin
      bps_cnt <= 0;
      clk_bps <= 1'b0;
    end else begin
      bps_cnt <= (bps_cnt == BIT - 1) ? 0 : bps_cnt + 1;
      clk_bps <= (bps_cnt == 24);
    end
  end

  always @(negedge clk) begin
    if (frame_err)  cnt_fe++;
    if (parity_err) cnt_pe++;
    if (overrun)    cnt_ov++;
    if (bps_start) hi_len++;
    else if (hi_len > 0) begin
      tests++;
      if (hi_len > NSTROBE * BIT) begin
        fails++;
        $display("FAIL bps_start_len: high %0d clocks, limit %0d", hi_len, NSTROBE * BIT);
      end
      hi_len = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit good_par(input bit [7:0] d);
    return bit'($countones(d) % 2) ^ PARITY_ODD;
  endfunction

  // Outcome of one complete frame, straight from the stop/parity/overrun priority rules
  task automatic model_frame(input bit [7:0] d, input bit stop_b, input bit par_b);
    if (!stop_b) exp_fe++;
    else if (PAR_EN && (bit'(($countones(d) + int'(par_b)) % 2) != PARITY_ODD)) exp_pe++;
    else if (exp_valid) exp_ov++;
    else begin
      exp_valid = 1'b1;
      exp_data  = d;
    end
  endtask

  task automatic send_frame(input bit [7:0] d, input bit stop_b, input bit par_b);
    @(negedge clk) rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_b;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_b;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bps_start, rx_valid, rx_data, frame_err, parity_err, overrun} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0", {bps_start, rx_valid, rx_data, frame_err, parity_err, overrun});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (bps_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: bps_start=%b required 0", bps_start);
    end
  endtask

  task automatic test_accept();
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    exp_valid = 1'b0;
    tests++;
    if (rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_clear: rx_valid=%b required 0", rx_valid);
    end
  endtask

  task automatic test_single();
    bit done = 1'b0;
    int s = 0;
    fork
      send_frame(8'hA5, 1'b1, good_par(8'hA5));
      begin
        for (int c = 0; c < NSTROBE * BIT + 200 && !done; c++) begin
          @(negedge clk);
          if (clk_bps) begin
            s++;
            if (s == NSTROBE) begin
              tests++;
              if (bps_start !== 1'b1 || rx_valid !== 1'b0) begin
                fails++;
                $display("FAIL last_strobe: bps_start=%b rx_valid=%b required 1 0", bps_start, rx_valid);
              end
              @(negedge clk);
              tests++;
              if (bps_start !== 1'b0 || rx_valid !== 1'b1) begin
                fails++;
                $display("FAIL after_strobe: bps_start=%b rx_valid=%b required 0 1", bps_start, rx_valid);
              end
              done = 1'b1;
            end
          end
        end
        if (!done) begin
          tests++; fails++;
          $display("FAIL strobe_timeout: saw %0d strobes required %0d", s, NSTROBE);
        end
      end
    join
    model_frame(8'hA5, 1'b1, good_par(8'hA5));
    tests++;
    if (rx_valid !== exp_valid || rx_data !== exp_data) begin
      fails++;
      $display("FAIL single_data: valid=%b data=%h required %b %h", rx_valid, rx_data, exp_valid, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    model_frame(8'h3C, 1'b1, good_par(8'h3C));
    send_frame(8'h81, 1'b1, good_par(8'h81));
    model_frame(8'h81, 1'b1, good_par(8'h81));
    tests++;
    if (cnt_ov !== exp_ov || rx_valid !== exp_valid || rx_data !== exp_data) begin
      fails++;
      $display("FAIL overrun: ov=%0d valid=%b data=%h required %0d %b %h",
               cnt_ov, rx_valid, rx_data, exp_ov, exp_valid, exp_data);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'hFF, 1'b0, good_par(8'hFF));
    model_frame(8'hFF, 1'b0, good_par(8'hFF));
    tests++;
    if (cnt_fe !== exp_fe || rx_valid !== exp_valid || bps_start !== 1'b0) begin
      fails++;
      $display("FAIL frame_err: fe=%0d valid=%b bps=%b required %0d %b 0",
               cnt_fe, rx_valid, bps_start, exp_fe, exp_valid);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk) rx = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (bps_start !== 1'b1) begin
      fails++;
      $display("FAIL glitch_start: bps_start=%b required 1", bps_start);
    end
    rx = 1'b1;
    repeat (60) @(negedge clk);
    tests++;
    if (bps_start !== 1'b0 || rx_valid !== exp_valid || cnt_fe !== exp_fe ||
        cnt_pe !== exp_pe || cnt_ov !== exp_ov) begin
      fails++;
      $display("FAIL glitch_end: bps=%b valid=%b fe=%0d pe=%0d ov=%0d required 0 %b %0d %0d %0d",
               bps_start, rx_valid, cnt_fe, cnt_pe, cnt_ov, exp_valid, exp_fe, exp_pe, exp_ov);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0);
    tests++;
    if (cnt_pe !== exp_pe || rx_valid !== exp_valid) begin
      fails++;
      $display("FAIL parity_bad: pe=%0d valid=%b required %0d %b", cnt_pe, rx_valid, exp_pe, exp_valid);
    end
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1);
    tests++;
    if (cnt_pe !== exp_pe || rx_valid !== exp_valid || rx_data !== exp_data) begin
      fails++;
      $display("FAIL parity_good: pe=%0d valid=%b data=%h required %0d %b %h",
               cnt_pe, rx_valid, rx_data, exp_pe, exp_valid, exp_data);
    end
  endtask

  task automatic test_reset_mid();
    bit [7:0] d = 8'hC3;
    @(negedge clk) rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = d[4];
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    tests++;
    if ({bps_start, rx_valid, rx_data, frame_err, parity_err, overrun} !== 13'h0) begin
      fails++;
      $display("FAIL reset_mid: got %b required 0", {bps_start, rx_valid, rx_data, frame_err, parity_err, overrun});
    end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (BIT * 6) @(negedge clk);
    send_frame(8'h55, 1'b1, good_par(8'h55));
    model_frame(8'h55, 1'b1, good_par(8'h55));
    tests++;
    if (rx_valid !== exp_valid || rx_data !== exp_data || cnt_fe !== exp_fe ||
        cnt_pe !== exp_pe || cnt_ov !== exp_ov) begin
      fails++;
      $display("FAIL reset_recover: valid=%b data=%h fe=%0d pe=%0d ov=%0d required %b %h %0d %0d %0d",
               rx_valid, rx_data, cnt_fe, cnt_pe, cnt_ov, exp_valid, exp_data, exp_fe, exp_pe, exp_ov);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      bit [7:0] d      = 8'($urandom);
      bit       stop_b = ($urandom_range(0, 4) != 0);
      bit       par_b  = good_par(d) ^ ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) test_accept();
      send_frame(d, stop_b, par_b);
      model_frame(d, stop_b, par_b);
      tests++;
      if (rx_valid !== exp_valid || (exp_valid && rx_data !== exp_data) || cnt_fe !== exp_fe ||
          cnt_pe !== exp_pe || cnt_ov !== exp_ov) begin
        fails++;
        $display("FAIL random_%0d: d=%h valid=%b data=%h fe=%0d pe=%0d ov=%0d required %b %h %0d %0d %0d",
                 n, d, rx_valid, rx_data, cnt_fe, cnt_pe, cnt_ov, exp_valid, exp_data, exp_fe, exp_pe, exp_ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_accept();
    test_back_to_back();
    test_accept();
    test_frame_err();
    test_glitch();
    if (PAR_EN) test_parity();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
